// File: rtl/bit_timing_fsm_pkg.sv
// -----------------------------------------------------------------------------
// bit_timing_fsm_pkg
// Shared definitions for the CAN bit-timing state machine: bit-segment state
// encodings, tq counter width, the counter-control bundle and a helper that
// turns the 2-bit sjw register into the resync jump width in tq.
// -----------------------------------------------------------------------------
package bit_timing_fsm_pkg;

   // Width of the external time-quanta counter (counto).
   localparam int CNT_W = 4;

   // Bit segments. Encodings are fixed so they line up with the rest of the
   // controller that decodes them.
   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_TSEG1 = 2'd1,
      ST_TSEG2 = 2'd2
   } bt_state_e;

   // Commands to the tq counter; at most one bit is set in any cycle.
   typedef struct packed {
      logic inc;   // count up
      logic zero;  // clear to 0
      logic two;   // load 2 (hard sync / negative resync into TSEG1)
   } cnt_ctrl_t;

   // SJW in tq = sjw + 1, range 1..4.
   function automatic logic [2:0] sjw_len(input logic [1:0] s);
      return {1'b0, s} + 3'd1;
   endfunction

endpackage

// File: rtl/bit_timing_fsm_edgedetect2.sv
// -----------------------------------------------------------------------------
// edgedetect2
// Recessive-to-dominant edge detector for the bit-timing FSM. The previous
// bus level is only refreshed on tq strobes, so an edge is seen as a 1->0
// change between two consecutive enabled cycles.
//
// Ports:
//   clock   in   system clock
//   reset   in   asynchronous reset, active low
//   i_en    in   tq strobe (Prescale_EN)
//   i_rx    in   synchronised bus level, 1 = recessive
//   o_edge  out  combinational edge flag, valid only while i_en = 1
// -----------------------------------------------------------------------------
module edgedetect2 (
   input  logic clock,
   input  logic reset,
   input  logic i_en,
   input  logic i_rx,
   output logic o_edge
);

   logic r_rx_prev;

   // Reset to recessive so an idle bus does not produce a spurious edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)     r_rx_prev <= 1'b1;
      else if (i_en)  r_rx_prev <= i_rx;
   end

   assign o_edge = i_en & r_rx_prev & ~i_rx;

endmodule

// File: rtl/bit_timing_fsm.sv
// -----------------------------------------------------------------------------
// bit_timing_fsm
// CAN bit-timing state machine. Splits each bit into SYNC_SEG, TSEG1 and
// TSEG2, steers the external tq counter, performs hard synchronisation and
// SJW-limited resynchronisation, and emits the sample / transmit strobes.
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous reset, active low
//   Prescale_EN  in   one-cycle tq strobe; nothing changes while it is 0
//   rx           in   synchronised bus level, 1 = recessive
//   tseg1[3:0]   in   TSEG1 length in tq (3..15)
//   tseg2[3:0]   in   TSEG2 length in tq (2..8)
//   sjw[1:0]     in   resync jump width minus one
//   hardsync_en  in   bus idle / SOF expected: edges hard-sync
//   txdom        in   node is driving dominant (suppresses positive resync)
//   counto[3:0]  in   tq counter value
//   increment    out  counter: count up           (combinational)
//   setctzero    out  counter: clear              (combinational)
//   setctotwo    out  counter: load 2             (combinational)
//   sample       out  one-clock pulse at the sample point (registered)
//   smpledbit    out  bus value captured at the last sample point
//   txpoint      out  one-clock pulse at start of SYNC_SEG (registered)
// -----------------------------------------------------------------------------
module bit_timing_fsm
   import bit_timing_fsm_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             Prescale_EN,
   input  logic             rx,
   input  logic [3:0]       tseg1,
   input  logic [3:0]       tseg2,
   input  logic [1:0]       sjw,
   input  logic             hardsync_en,
   input  logic             txdom,
   input  logic [CNT_W-1:0] counto,
   output logic             increment,
   output logic             setctzero,
   output logic             setctotwo,
   output logic             sample,
   output logic             smpledbit,
   output logic             txpoint
);

   bt_state_e  r_state, w_state_nxt;
   logic [2:0] r_ext, w_ext_nxt;         // TSEG1 lengthening from positive resync
   logic [2:0] r_shr, w_shr_nxt;         // TSEG2 shortening from negative resync
   logic       r_resync_done, w_resync_done_nxt;
   cnt_ctrl_t  w_ctrl;
   logic       w_sample_nxt, w_txpoint_nxt, w_capture;

   logic       w_edge, w_hsync, w_resync_ok, w_pos_resync;
   logic [2:0] w_sjw_len, w_ext_cand, w_ext_eff;
   logic       w_t1_last, w_t2_last, w_neg_near;

   edgedetect2 u_edge (
      .clock  (clock),
      .reset  (reset),
      .i_en   (Prescale_EN),
      .i_rx   (rx),
      .o_edge (w_edge)
   );

   assign w_sjw_len    = sjw_len(sjw);
   assign w_hsync      = w_edge & hardsync_en;
   // Hard sync takes precedence, so resync only when hardsync_en is low.
   assign w_resync_ok  = w_edge & ~hardsync_en & ~r_resync_done;
   assign w_pos_resync = w_resync_ok & ~txdom & (r_state == ST_TSEG1);

   // ext = min(counto, SJW); counto[2:0] is exact whenever counto < SJW <= 4.
   assign w_ext_cand = ({1'b0, counto} < {2'b00, w_sjw_len}) ? counto[2:0] : w_sjw_len;
   // The TSEG1 end test in a resync cycle already uses the new extension.
   assign w_ext_eff  = w_pos_resync ? w_ext_cand : r_ext;

   // End-of-segment and negative-resync tests are written with additions only
   // so nothing can wrap below zero.
   //   TSEG1 ends at counto == L1 - 1 + ext
   //   TSEG2 ends at counto == L2 - 1 - shr
   //   jump straight to TSEG1 when L2 - 1 - counto <= SJW
   assign w_t1_last  = ({1'b0, counto} + 5'd1) == ({1'b0, tseg1} + {2'b00, w_ext_eff});
   assign w_t2_last  = ({1'b0, counto} + {2'b00, r_shr} + 5'd1) == {1'b0, tseg2};
   assign w_neg_near = ({1'b0, counto} + {2'b00, w_sjw_len} + 5'd1) >= {1'b0, tseg2};

   always_comb begin
      w_state_nxt       = r_state;
      w_ext_nxt         = r_ext;
      w_shr_nxt         = r_shr;
      w_resync_done_nxt = r_resync_done;
      w_ctrl            = '0;
      w_sample_nxt      = 1'b0;
      w_txpoint_nxt     = 1'b0;
      w_capture         = 1'b0;

      if (Prescale_EN) begin
         if (w_hsync) begin
            // Counter restarts at 2: the edge was seen two tq late.
            w_ctrl.two        = 1'b1;
            w_state_nxt       = ST_TSEG1;
            w_ext_nxt         = 3'd0;
            w_shr_nxt         = 3'd0;
            w_resync_done_nxt = 1'b1;
         end else begin
            case (r_state)
               ST_SYNC: begin
                  w_ctrl.zero   = 1'b1;
                  w_txpoint_nxt = 1'b1;
                  w_state_nxt   = ST_TSEG1;
               end
               ST_TSEG1: begin
                  if (w_pos_resync) begin
                     w_ext_nxt         = w_ext_cand;
                     w_resync_done_nxt = 1'b1;
                  end
                  if (w_t1_last) begin
                     w_ctrl.zero       = 1'b1;
                     w_state_nxt       = ST_TSEG2;
                     w_sample_nxt      = 1'b1;
                     w_capture         = 1'b1;
                     w_ext_nxt         = 3'd0;
                     w_resync_done_nxt = 1'b0;
                  end else begin
                     w_ctrl.inc = 1'b1;
                  end
               end
               ST_TSEG2: begin
                  if (w_resync_ok && w_neg_near) begin
                     // Remaining TSEG2 fits inside SJW: drop it and SYNC_SEG.
                     w_ctrl.two        = 1'b1;
                     w_state_nxt       = ST_TSEG1;
                     w_resync_done_nxt = 1'b1;
                  end else begin
                     if (w_resync_ok) begin
                        w_shr_nxt         = w_sjw_len;
                        w_resync_done_nxt = 1'b1;
                     end
                     // A far edge leaves counto well short of the end, so
                     // testing against the old shr is exact here.
                     if (w_t2_last) begin
                        w_ctrl.zero = 1'b1;
                        w_state_nxt = ST_SYNC;
                        w_shr_nxt   = 3'd0;
                     end else begin
                        w_ctrl.inc = 1'b1;
                     end
                  end
               end
               default: begin
                  // Unused encoding: restart the bit.
                  w_ctrl.zero = 1'b1;
                  w_state_nxt = ST_SYNC;
               end
            endcase
         end
      end
   end

   // Counter controls are held low while reset is asserted.
   assign increment = w_ctrl.inc  & reset;
   assign setctzero = w_ctrl.zero & reset;
   assign setctotwo = w_ctrl.two  & reset;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_SYNC;
         r_ext         <= 3'd0;
         r_shr         <= 3'd0;
         r_resync_done <= 1'b0;
         sample        <= 1'b0;
         txpoint       <= 1'b0;
         smpledbit     <= 1'b1;
      end else begin
         r_state       <= w_state_nxt;
         r_ext         <= w_ext_nxt;
         r_shr         <= w_shr_nxt;
         r_resync_done <= w_resync_done_nxt;
         sample        <= w_sample_nxt;
         txpoint       <= w_txpoint_nxt;
         if (w_capture) smpledbit <= rx;
      end
   end

endmodule
